// File: rtl/shift_pipe_unit.sv
// shift_pipe_unit: pipelined barrel shifter/rotator with a valid/ready handshake.
// Stage k applies shift level 2**(SHAMT_W-1-k), MSB level first. Each stage holds
// valid, data, shamt, op, carry and err. The output port is the last stage register.
module shift_pipe_unit #(
  parameter int unsigned SHAMT_W = 5,
  parameter int unsigned WIDTH   = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [2:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_carry,
  output logic               out_err
);

  localparam int unsigned DEPTH = SHAMT_W;

  localparam logic [2:0] OP_SLL = 3'd0;
  localparam logic [2:0] OP_SRL = 3'd1;
  localparam logic [2:0] OP_SRA = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;

  logic [DEPTH-1:0]              valid_q;
  logic [DEPTH-1:0]              carry_q;
  logic [DEPTH-1:0]              err_q;
  logic [DEPTH-1:0][WIDTH-1:0]   data_q;
  logic [DEPTH-1:0][SHAMT_W-1:0] shamt_q;
  logic [DEPTH-1:0][2:0]         op_q;
  logic [DEPTH-1:0]              stage_ready_c;

  // One shift level, returned as {carry, data}. A disabled level or a reserved op
  // forwards data and carry untouched. The extra bit of each wide shift catches
  // the last bit pushed out of the word.
  function automatic logic [WIDTH:0] level_shift(
    input logic [WIDTH-1:0] d,
    input logic [2:0]       op,
    input logic             en,
    input logic             c,
    input int unsigned      lvl
  );
    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] rot;
    level_shift = {c, d};
    wide        = '0;
    rot         = '0;
    if (en) begin
      case (op)
        OP_SLL: begin
          wide        = {1'b0, d} << lvl;
          level_shift = wide;
        end
        OP_SRL: begin
          wide        = {d, 1'b0} >> lvl;
          level_shift = {wide[0], wide[WIDTH:1]};
        end
        OP_SRA: begin
          wide        = $unsigned($signed({d, 1'b0}) >>> lvl);
          level_shift = {wide[0], wide[WIDTH:1]};
        end
        OP_ROL: begin
          rot         = (d << lvl) | (d >> (WIDTH - lvl));
          level_shift = {rot[0], rot};
        end
        OP_ROR: begin
          rot         = (d >> lvl) | (d << (WIDTH - lvl));
          level_shift = {rot[WIDTH-1], rot};
        end
        default: level_shift = {c, d};
      endcase
    end
  endfunction

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    localparam int unsigned LVL = 32'd1 << (DEPTH - 1 - k);

    logic               src_valid;
    logic [WIDTH-1:0]   src_data;
    logic [SHAMT_W-1:0] src_shamt;
    logic [2:0]         src_op;
    logic               src_carry;
    logic               src_err;
    logic [WIDTH:0]     step_c;

    if (k == 0) begin : g_head
      // First stage takes the operand from the port and flags reserved ops
      always_comb begin
        src_valid = in_valid;
        src_data  = in_data;
        src_shamt = in_shamt;
        src_op    = in_op;
        src_carry = 1'b0;
        src_err   = (in_op > OP_ROR);
      end
    end else begin : g_body
      // Later stages take their operand from the previous stage register
      always_comb begin
        src_valid = valid_q[k-1];
        src_data  = data_q[k-1];
        src_shamt = shamt_q[k-1];
        src_op    = op_q[k-1];
        src_carry = carry_q[k-1];
        src_err   = err_q[k-1];
      end
    end

    assign step_c = level_shift(src_data, src_op, src_shamt[DEPTH-1-k], src_carry, LVL);

    // Stage k can load when it, or any stage after it, has room, or the sink drains
    assign stage_ready_c[k] = out_ready | ~(&valid_q[DEPTH-1:k]);

    // Stage register: loads on advance, holds while stalled, clears on reset
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        valid_q[k] <= 1'b0;
        data_q[k]  <= '0;
        shamt_q[k] <= '0;
        op_q[k]    <= '0;
        carry_q[k] <= 1'b0;
        err_q[k]   <= 1'b0;
      end else if (stage_ready_c[k]) begin
        valid_q[k] <= src_valid;
        if (src_valid) begin
          data_q[k]  <= step_c[WIDTH-1:0];
          shamt_q[k] <= src_shamt;
          op_q[k]    <= src_op;
          carry_q[k] <= step_c[WIDTH];
          err_q[k]   <= src_err;
        end
      end
    end
  end

  // Stage copies of shamt/op beyond the bits consumed downstream are kept for visibility
  logic unused_stage_fields;
  assign unused_stage_fields = ^{shamt_q, op_q};

  assign in_ready  = stage_ready_c[0] & ~reset;
  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign out_carry = carry_q[DEPTH-1];
  assign out_err   = err_q[DEPTH-1];

endmodule

// File: tb/tb_shift_pipe_unit.sv
// Scoreboard bench for shift_pipe_unit: the driver pushes model results on acceptance,
// and an independent monitor pops and compares on every output transfer.
module tb_shift_pipe_unit;

  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned WIDTH   = 32;
  localparam int unsigned DEPTH   = SHAMT_W;

  localparam logic [2:0] OP_SLL = 3'd0;
  localparam logic [2:0] OP_SRL = 3'd1;
  localparam logic [2:0] OP_SRA = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             carry;
    logic             err;
    int               acc;
    bit               lat;
  } exp_t;

  logic               clock;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [2:0]         in_op;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_carry;
  logic               out_err;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  bit   saw_bp;
  bit   rnd_done;
  exp_t exp_q[$];
  exp_t mon_e;

  logic [2:0]         op;
  logic [WIDTH-1:0]   d;
  logic [SHAMT_W-1:0] s;

  shift_pipe_unit #(.SHAMT_W(SHAMT_W), .WIDTH(WIDTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .out_err   (out_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "simulation timeout");
  end

  function automatic void chk(input string name, input logic [WIDTH-1:0] act,
                              input logic [WIDTH-1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
  endfunction

  function automatic logic bit_of(input logic [WIDTH-1:0] v, input int idx);
    logic [WIDTH-1:0] t;
    t = v >> idx;
    return t[0];
  endfunction

  function automatic exp_t mk(input logic [WIDTH-1:0] data, input logic carry, input logic err);
    exp_t e;
    e.data = data; e.carry = carry; e.err = err; e.acc = 0; e.lat = 1'b0;
    return e;
  endfunction

  // Reference: each result bit is picked from its source bit position in the operand
  function automatic exp_t model(input logic [2:0] mop, input logic [WIDTH-1:0] md,
                                 input logic [SHAMT_W-1:0] ms);
    exp_t             e;
    int               sh;
    int               w;
    logic             b;
    logic [WIDTH-1:0] r;
    sh = int'(ms);
    w  = int'(WIDTH);
    e  = mk(md, 1'b0, 1'b0);
    if (mop > OP_ROR) begin
      e.err = 1'b1;
      return e;
    end
    r = '0;
    for (int i = 0; i < w; i++) begin
      case (mop)
        OP_SLL:  b = (i >= sh) ? bit_of(md, i - sh) : 1'b0;
        OP_SRL:  b = (i + sh < w) ? bit_of(md, i + sh) : 1'b0;
        OP_SRA:  b = (i + sh < w) ? bit_of(md, i + sh) : md[WIDTH-1];
        OP_ROL:  b = bit_of(md, (i - sh + w) % w);
        default: b = bit_of(md, (i + sh) % w);
      endcase
      r = r | (WIDTH'(b) << i);
    end
    e.data = r;
    if (sh != 0) begin
      case (mop)
        OP_SLL:  e.carry = bit_of(md, w - sh);
        OP_SRL:  e.carry = bit_of(md, sh - 1);
        OP_SRA:  e.carry = bit_of(md, sh - 1);
        OP_ROL:  e.carry = r[0];
        default: e.carry = r[WIDTH-1];
      endcase
    end
    return e;
  endfunction

  // Present one transaction from posedge+1 until accepted; leaves at posedge+1
  task automatic issue(input logic [2:0] iop, input logic [WIDTH-1:0] id,
                       input logic [SHAMT_W-1:0] is, input bit lat, input exp_t e);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_op    = iop;
    in_data  = id;
    in_shamt = is;
    @(negedge clock);
    while (!in_ready && guard < 1000) begin
      saw_bp = 1'b1;
      guard++;
      @(negedge clock);
    end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL in_ready_timeout: got in_ready=0 for 1000 cycles, expected 1");
    end else begin
      e.acc = cyc + 1;
      e.lat = lat;
      exp_q.push_back(e);
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(posedge clock);
      guard++;
    end
    #1;
    chk("drain_empty", WIDTH'(exp_q.size()), '0);
    repeat (2) @(posedge clock);
    #1;
  endtask

  // Monitor: compare every output transfer against the head of the scoreboard
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output: got 0x%0h with empty scoreboard, expected no output",
                   out_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_data", out_data, mon_e.data);
          chk("out_carry", WIDTH'(out_carry), WIDTH'(mon_e.carry));
          chk("out_err", WIDTH'(out_err), WIDTH'(mon_e.err));
          if (mon_e.lat) chk("latency", WIDTH'(cyc - mon_e.acc), WIDTH'(DEPTH - 1));
        end
      end
    end
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_op     = '0;
    out_ready = 1'b1;
    saw_bp    = 1'b0;
    rnd_done  = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    chk("rst_out_valid", WIDTH'(out_valid), '0);
    chk("rst_in_ready", WIDTH'(in_ready), '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_carry", WIDTH'(out_carry), '0);
    chk("rst_out_err", WIDTH'(out_err), '0);
    reset = 1'b0;
    @(negedge clock);
    chk("in_ready_after_reset", WIDTH'(in_ready), 32'd1);
    @(posedge clock);
    #1;

    // Directed cases with literal expectations and nominal latency
    issue(OP_SRA, 32'h8000_0000, 5'd4, 1'b1, mk(32'hF800_0000, 1'b0, 1'b0));
    issue(OP_SRL, 32'h8000_0001, 5'd1, 1'b1, mk(32'h4000_0000, 1'b1, 1'b0));
    issue(OP_SLL, 32'h8000_0001, 5'd1, 1'b1, mk(32'h0000_0002, 1'b1, 1'b0));
    issue(OP_ROL, 32'h8000_0001, 5'd4, 1'b1, mk(32'h0000_0018, 1'b0, 1'b0));
    issue(OP_ROR, 32'h0000_0001, 5'd31, 1'b1, mk(32'h0000_0002, 1'b0, 1'b0));
    for (int i = 0; i < 5; i++)
      issue(3'(i), 32'hDEAD_BEEF, 5'd0, 1'b1, mk(32'hDEAD_BEEF, 1'b0, 1'b0));
    issue(3'b110, 32'h1234_5678, 5'd7, 1'b1, mk(32'h1234_5678, 1'b0, 1'b1));
    issue(OP_SLL, 32'h0000_0003, 5'd31, 1'b1, mk(32'h8000_0000, 1'b1, 1'b0));
    issue(OP_SRA, 32'h8000_0000, 5'd31, 1'b1, mk(32'hFFFF_FFFF, 1'b0, 1'b0));
    issue(OP_SRL, 32'hC000_0000, 5'd31, 1'b1, mk(32'h0000_0001, 1'b1, 1'b0));
    issue(3'b101, 32'hA5A5_0F0F, 5'd3, 1'b1, mk(32'hA5A5_0F0F, 1'b0, 1'b1));
    issue(3'b111, 32'h0000_0001, 5'd31, 1'b1, mk(32'h0000_0001, 1'b0, 1'b1));
    drain();

    // Eight back-to-back SRAs with a six-cycle output stall in the middle
    saw_bp = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          d = $urandom();
          if (i % 2 == 0) d = d | 32'h8000_0000;
          s = SHAMT_W'($urandom());
          issue(OP_SRA, d, s, 1'b0, model(OP_SRA, d, s));
        end
      end
      begin
        repeat (3) @(posedge clock);
        #1;
        out_ready = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        out_ready = 1'b1;
      end
    join
    chk("in_ready_dropped", WIDTH'(saw_bp), 32'd1);
    drain();

    // Asynchronous reset with three transactions in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d = $urandom() | 32'h0000_0001;
      s = SHAMT_W'($urandom());
      issue(OP_ROL, d, s, 1'b0, model(OP_ROL, d, s));
    end
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clock);
    chk("out_valid_before_reset", WIDTH'(out_valid), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("async_out_valid", WIDTH'(out_valid), '0);
    chk("async_out_data", out_data, '0);
    chk("async_out_carry", WIDTH'(out_carry), '0);
    chk("async_out_err", WIDTH'(out_err), '0);
    chk("async_in_ready", WIDTH'(in_ready), '0);
    exp_q.delete();
    @(posedge clock);
    #1;
    chk("in_ready_during_reset", WIDTH'(in_ready), '0);
    @(posedge clock);
    #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    chk("in_ready_after_release", WIDTH'(in_ready), 32'd1);
    chk("out_valid_after_release", WIDTH'(out_valid), '0);
    repeat (8) @(negedge clock);
    chk("no_stale_output", WIDTH'(out_valid), '0);
    @(posedge clock);
    #1;
    issue(OP_ROR, 32'h0000_00A5, 5'd3, 1'b1, mk(32'hA000_0014, 1'b1, 1'b0));
    drain();

    // Random traffic with random downstream back-pressure
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          op = 3'($urandom_range(0, 7));
          d  = $urandom();
          s  = SHAMT_W'($urandom());
          issue(op, d, s, 1'b0, model(op, d, s));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clock);
            #1;
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clock);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
